// File: rtl/sram_burst_ctrl_if.sv
// Memory-stage <-> SRAM controller request/response bundle.
// Latency: none, wires only.
// Backpressure: requests are held by the master until done; pause stalls the pipeline meanwhile.
//
// Signals:
//   wr_req/rd_req   : level requests from the memory stage, held until done
//   address         : byte address of the access
//   wr_data         : write word (WR_W bits)
//   rd_data         : assembled read line (RD_W bits), beat 0 in LSBs
//   done            : one-cycle completion pulse
//   pause           : stall towards the other pipeline stages
interface sram_burst_ctrl_if #(
    parameter int WR_W = 32,
    parameter int RD_W = 64
);
    logic            wr_req;
    logic            rd_req;
    logic [31:0]     address;
    logic [WR_W-1:0] wr_data;
    logic [RD_W-1:0] rd_data;
    logic            done;
    logic            pause;

    modport master (
        output wr_req, rd_req, address, wr_data,
        input  rd_data, done, pause
    );

    modport slave (
        input  wr_req, rd_req, address, wr_data,
        output rd_data, done, pause
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst controller for an asynchronous SRAM: serialises word writes, gathers line reads.
// Latency: 1 + beats*(1+WAIT_CYC) cycles from request to the done pulse.
// Backpressure: pause holds the pipeline while a request is pending and not yet done.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : slave side of sram_burst_ctrl_if (requests, address, data, done, pause)
//   SRAM_DQ     : bidirectional SRAM data, driven only while writing
//   SRAM_ADDR   : registered SRAM word address
//   SRAM_*_N    : SRAM strobes; UB/LB/CE tied active, OE_N high only while writing,
//                 WE_N registered low for every cycle of a write burst
module sram_burst_ctrl #(
    parameter int SRAM_DW    = 16,
    parameter int SRAM_AW    = 18,
    parameter int WR_BEATS   = 2,
    parameter int LINE_BEATS = 4,
    parameter int WAIT_CYC   = 0
) (
    input  logic                clk,
    input  logic                rst,
    sram_burst_ctrl_if.slave    bus,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N
);
    localparam int B  = $clog2(SRAM_DW / 8);
    localparam int CW = $clog2(LINE_BEATS) + 1;

    localparam logic [SRAM_AW-1:0] WR_MASK   = SRAM_AW'(WR_BEATS - 1);
    localparam logic [SRAM_AW-1:0] LINE_MASK = SRAM_AW'(LINE_BEATS - 1);
    localparam logic [CW-1:0]      WR_LAST   = CW'(WR_BEATS - 1);
    localparam logic [CW-1:0]      RD_LAST   = CW'(LINE_BEATS - 1);
    localparam logic [2:0]         WAIT_LAST = 3'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t                         state;
    logic [CW-1:0]                  beat;
    logic [CW-1:0]                  next_beat;
    logic [2:0]                     wait_cnt;
    logic                           beat_end;
    logic                           dq_en;
    logic [SRAM_AW-1:0]             burst_base;
    logic [WR_BEATS*SRAM_DW-1:0]    wr_buf;
    logic [31:0]                    addr_words;
    logic [SRAM_AW-1:0]             base_addr;
    logic                           unused_addr_hi;

    assign addr_words     = bus.address >> B;
    assign base_addr      = addr_words[SRAM_AW-1:0];
    assign unused_addr_hi = ^addr_words[31:SRAM_AW];

    assign next_beat = beat + 1'b1;
    assign beat_end  = (wait_cnt == WAIT_LAST);

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

    // The write word is captured at burst start so a request dropped
    // mid-burst cannot corrupt the remaining beats.
    assign SRAM_DQ = dq_en ? wr_buf[int'(beat)*SRAM_DW +: SRAM_DW] : {SRAM_DW{1'bz}};

    // done is registered, so pause falls in the same cycle done rises.
    assign bus.pause = (bus.wr_req | bus.rd_req) & ~bus.done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            beat        <= '0;
            wait_cnt    <= '0;
            SRAM_ADDR   <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b0;
            dq_en       <= 1'b0;
            burst_base  <= '0;
            wr_buf      <= '0;
            bus.rd_data <= '0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    beat     <= '0;
                    wait_cnt <= '0;
                    // Write wins over a simultaneous read; the read is
                    // picked up here again once the write is done.
                    if (bus.wr_req) begin
                        state      <= S_WRITE;
                        burst_base <= base_addr & ~WR_MASK;
                        SRAM_ADDR  <= base_addr & ~WR_MASK;
                        wr_buf     <= bus.wr_data;
                        SRAM_WE_N  <= 1'b0;
                        SRAM_OE_N  <= 1'b1;
                        dq_en      <= 1'b1;
                    end else if (bus.rd_req) begin
                        state      <= S_READ;
                        burst_base <= base_addr & ~LINE_MASK;
                        SRAM_ADDR  <= base_addr & ~LINE_MASK;
                    end
                end

                S_WRITE: begin
                    if (beat_end) begin
                        wait_cnt <= '0;
                        if (beat == WR_LAST) begin
                            state     <= S_DONE;
                            bus.done  <= 1'b1;
                            SRAM_WE_N <= 1'b1;
                            SRAM_OE_N <= 1'b0;
                            dq_en     <= 1'b0;
                        end else begin
                            beat      <= next_beat;
                            SRAM_ADDR <= burst_base | SRAM_AW'(next_beat);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end

                S_READ: begin
                    if (beat_end) begin
                        // Sample on the last edge of the beat so wait
                        // states give the SRAM its full access time.
                        bus.rd_data[int'(beat)*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
                        wait_cnt <= '0;
                        if (beat == RD_LAST) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            beat      <= next_beat;
                            SRAM_ADDR <= burst_base | SRAM_AW'(next_beat);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: three instances (defaults, two wait states, 32-bit bus
// with 8-beat lines and single-beat writes), each with a small asynchronous SRAM model.
// Expected traces come from the address-mapping and latency rules plus a word-level
// memory image; a single negedge process compares the DUT against them.
module tb_sram_burst_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_a   [3];
    logic        wr_req_a[3];
    logic        rd_req_a[3];
    logic [31:0] addr_a  [3];
    logic [31:0] wd_a    [3];

    sram_burst_ctrl_if #(.WR_W(32), .RD_W(64))  if0 ();
    sram_burst_ctrl_if #(.WR_W(32), .RD_W(64))  if1 ();
    sram_burst_ctrl_if #(.WR_W(32), .RD_W(256)) if2 ();

    assign if0.wr_req = wr_req_a[0]; assign if0.rd_req = rd_req_a[0];
    assign if0.address = addr_a[0];  assign if0.wr_data = wd_a[0];
    assign if1.wr_req = wr_req_a[1]; assign if1.rd_req = rd_req_a[1];
    assign if1.address = addr_a[1];  assign if1.wr_data = wd_a[1];
    assign if2.wr_req = wr_req_a[2]; assign if2.rd_req = rd_req_a[2];
    assign if2.address = addr_a[2];  assign if2.wr_data = wd_a[2];

    wire  [15:0] dq0, dq1;
    wire  [31:0] dq2;
    logic [17:0] sa0, sa1, sa2;
    logic        ub0, lb0, ce0, oe0, we0;
    logic        ub1, lb1, ce1, oe1, we1;
    logic        ub2, lb2, ce2, oe2, we2;

    sram_burst_ctrl u0 (
        .clk(clk), .rst(rst_a[0]), .bus(if0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_WE_N(we0)
    );
    sram_burst_ctrl #(.WAIT_CYC(2)) u1 (
        .clk(clk), .rst(rst_a[1]), .bus(if1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1)
    );
    sram_burst_ctrl #(.SRAM_DW(32), .WR_BEATS(1), .LINE_BEATS(8)) u2 (
        .clk(clk), .rst(rst_a[2]), .bus(if2), .SRAM_DQ(dq2), .SRAM_ADDR(sa2),
        .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2), .SRAM_WE_N(we2)
    );

    // Asynchronous SRAM models: 32 words each (upper address bits alias).
    logic [15:0] smem0[32];
    logic [15:0] smem1[32];
    logic [31:0] smem2[32];
    assign dq0 = (!oe0 && we0) ? smem0[sa0[4:0]] : 16'bz;
    assign dq1 = (!oe1 && we1) ? smem1[sa1[4:0]] : 16'bz;
    assign dq2 = (!oe2 && we2) ? smem2[sa2[4:0]] : 32'bz;
    always @(negedge clk) if (!we0) smem0[sa0[4:0]] <= dq0;
    always @(negedge clk) if (!we1) smem1[sa1[4:0]] <= dq1;
    always @(negedge clk) if (!we2) smem2[sa2[4:0]] <= dq2;

    // Uniform views of the three instances.
    logic [255:0] rdat[3];
    logic [17:0]  sa  [3];
    logic [31:0]  dqv [3];
    logic         we  [3];
    logic         oe  [3];
    logic         dn  [3];
    logic         ps  [3];
    assign rdat[0] = {192'b0, if0.rd_data}; assign rdat[1] = {192'b0, if1.rd_data};
    assign rdat[2] = if2.rd_data;
    assign sa[0] = sa0; assign sa[1] = sa1; assign sa[2] = sa2;
    assign dqv[0] = {16'b0, dq0}; assign dqv[1] = {16'b0, dq1}; assign dqv[2] = dq2;
    assign we[0] = we0; assign we[1] = we1; assign we[2] = we2;
    assign oe[0] = oe0; assign oe[1] = oe1; assign oe[2] = oe2;
    assign dn[0] = if0.done; assign dn[1] = if1.done; assign dn[2] = if2.done;
    assign ps[0] = if0.pause; assign ps[1] = if1.pause; assign ps[2] = if2.pause;

    function automatic int dw_of(input int i); return (i == 2) ? 32 : 16; endfunction
    function automatic int wb_of(input int i); return (i == 2) ? 1 : 2;   endfunction
    function automatic int lb_of(input int i); return (i == 2) ? 8 : 4;   endfunction
    function automatic int wc_of(input int i); return (i == 1) ? 2 : 0;   endfunction

    // Word-level image of what each SRAM must hold.
    logic [31:0] refm[3][32];

    // Expectation for the current cycle, consumed by the compare process.
    bit           e_vld = 1'b0;
    int           e_dut = 0;
    int           e_cyc = 0;
    bit           e_done, e_pause, e_beat, e_wr, e_rdchk;
    logic [17:0]  e_addr;
    logic [31:0]  e_dq;
    logic [255:0] e_line;
    int           last_done = -1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d cyc=%0d got=%h want=%h", nm, e_dut, e_cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (e_vld) begin
            chk("done", 256'(dn[e_dut]), 256'(e_done));
            chk("pause", 256'(ps[e_dut]), 256'(e_pause));
            if (e_beat) begin
                chk("addr", 256'(sa[e_dut]), 256'(e_addr));
                chk("we_n", 256'(we[e_dut]), 256'(!e_wr));
                chk("oe_n", 256'(oe[e_dut]), 256'(e_wr));
                if (e_wr) chk("dq", 256'(dqv[e_dut]), 256'(e_dq));
            end else begin
                chk("we_n_idle", 256'(we[e_dut]), 256'(1'b1));
                chk("oe_n_idle", 256'(oe[e_dut]), 256'(1'b0));
            end
            if (e_rdchk) chk("rd_data", rdat[e_dut], e_line);
            if (dn[e_dut]) last_done = e_cyc;
        end
    end

    // One transaction: cycle 0 is the request cycle, done is due in cycle T.
    task automatic run(input int i, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input bit drop, input bit keep_rd);
        int           dw, beats, per, T, bt;
        logic [31:0]  t, msk;
        logic [17:0]  lo;
        logic [255:0] line;
        dw    = dw_of(i);
        beats = wr ? wb_of(i) : lb_of(i);
        per   = 1 + wc_of(i);
        T     = 1 + beats * per;
        t     = (a >> ((dw == 16) ? 1 : 2)) & ~(32'(beats) - 32'd1);
        lo    = t[17:0];
        msk   = (dw == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        line  = '0;
        if (!wr)
            for (int b = 0; b < beats; b++)
                line |= 256'(refm[i][(int'(lo) + b) & 31]) << (b * dw);
        wr_req_a[i] = wr;
        rd_req_a[i] = !wr || keep_rd;
        addr_a[i]   = a;
        wd_a[i]     = wd;
        last_done   = -1;
        for (int c = 0; c <= T; c++) begin
            if (c == 1 && drop) begin
                wr_req_a[i] = 1'b0;
                rd_req_a[i] = keep_rd;
            end
            bt      = (c >= 1) ? (c - 1) / per : 0;
            e_dut   = i;
            e_cyc   = c;
            e_done  = (c == T);
            e_pause = (wr_req_a[i] || rd_req_a[i]) && (c != T);
            e_beat  = (c >= 1) && (c < T);
            e_addr  = lo + 18'(bt);
            e_wr    = wr;
            e_dq    = (wd >> (bt * dw)) & msk;
            e_rdchk = !wr && (c == T);
            e_line  = line;
            e_vld   = 1'b1;
            @(posedge clk); #1;
        end
        e_vld       = 1'b0;
        wr_req_a[i] = 1'b0;
        rd_req_a[i] = keep_rd;
        if (wr)
            for (int b = 0; b < beats; b++)
                refm[i][(int'(lo) + b) & 31] = (wd >> (b * dw)) & msk;
    endtask

    task automatic idle(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            e_dut = i; e_cyc = -1; e_done = 1'b0; e_pause = 1'b0;
            e_beat = 1'b0; e_rdchk = 1'b0; e_vld = 1'b1;
            @(posedge clk); #1;
        end
        e_vld = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b0; wr_req_a[i] = 1'b0; rd_req_a[i] = 1'b0;
            addr_a[i] = '0; wd_a[i] = '0;
        end
        #1;
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            e_dut = i;
            chk("rst_we_n", 256'(we[i]), 256'(1'b1));
            chk("rst_oe_n", 256'(oe[i]), 256'(1'b0));
            chk("rst_addr", 256'(sa[i]), 256'(0));
            chk("rst_rd_data", rdat[i], 256'(0));
            chk("rst_done", 256'(dn[i]), 256'(0));
        end
        chk("tie_ub_lb_ce", 256'({ub0, lb0, ce0, ub1, lb1, ce1, ub2, lb2, ce2}), 256'(0));
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
        @(posedge clk); #1;

        // Fill every modelled SRAM word so later reads have known contents.
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 32; w += wb_of(i))
                run(i, 1'b1, 32'(w) << ((i == 2) ? 2 : 1), $urandom, 1'b0, 1'b0);

        // Single write with defaults.
        run(0, 1'b1, 32'h0000_0104, 32'hBEEF_CAFE, 1'b0, 1'b0);
        chk("s1_latency", 256'(last_done), 256'(3));
        chk("s1_mem_lo", 256'(smem0[2]), 256'(16'hCAFE));
        chk("s1_mem_hi", 256'(smem0[3]), 256'(16'hBEEF));

        // Line read; 0x8C maps to word 0x46, i.e. line 0x44..0x47.
        run(0, 1'b1, 32'h0000_0088, 32'h2222_1111, 1'b0, 1'b0);
        run(0, 1'b1, 32'h0000_008C, 32'h4444_3333, 1'b0, 1'b0);
        run(0, 1'b0, 32'h0000_008C, 32'h0, 1'b0, 1'b0);
        chk("s2_latency", 256'(last_done), 256'(5));
        chk("s2_line", rdat[0], 256'(64'h4444_3333_2222_1111));

        // Same read with two wait states.
        run(1, 1'b1, 32'h0000_0088, 32'h2222_1111, 1'b0, 1'b0);
        run(1, 1'b1, 32'h0000_008C, 32'h4444_3333, 1'b0, 1'b0);
        run(1, 1'b0, 32'h0000_008C, 32'h0, 1'b0, 1'b0);
        chk("s3_latency", 256'(last_done), 256'(13));
        chk("s3_line", rdat[1], 256'(64'h4444_3333_2222_1111));

        // Write and read together: write first, read follows after one idle cycle.
        run(0, 1'b1, 32'h0000_0088, 32'hAAAA_5555, 1'b0, 1'b1);
        chk("s4_wr_latency", 256'(last_done), 256'(3));
        run(0, 1'b0, 32'h0000_0088, 32'h0, 1'b0, 1'b0);
        chk("s4_rd_latency", 256'(last_done), 256'(5));
        chk("s4_line", rdat[0], 256'(64'h4444_3333_AAAA_5555));

        // Reset in the middle of read beat 2.
        rd_req_a[0] = 1'b1; addr_a[0] = 32'h0000_008C;
        repeat (3) @(posedge clk);
        #2;
        rst_a[0] = 1'b1;
        #1;
        e_dut = 0;
        chk("s5_we_n", 256'(we0), 256'(1'b1));
        chk("s5_oe_n", 256'(oe0), 256'(1'b0));
        chk("s5_addr", 256'(sa0), 256'(0));
        chk("s5_rd_data", rdat[0], 256'(0));
        chk("s5_done", 256'(dn[0]), 256'(0));
        rd_req_a[0] = 1'b0;
        @(posedge clk); #1;
        rst_a[0] = 1'b0;
        idle(0, 4);
        run(0, 1'b0, 32'h0000_008C, 32'h0, 1'b0, 1'b0);
        chk("s5_fresh_latency", 256'(last_done), 256'(5));
        chk("s5_fresh_line", rdat[0], 256'(64'h4444_3333_AAAA_5555));

        // 32-bit bus, single-beat writes, 8-beat lines.
        run(2, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("s6_wr_latency", 256'(last_done), 256'(2));
        run(2, 1'b1, 32'h0000_011C, 32'h0BAD_F00D, 1'b0, 1'b0);
        run(2, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 1'b0);
        chk("s6_rd_latency", 256'(last_done), 256'(9));
        chk("s6_line_lo", 256'(rdat[2][31:0]), 256'(32'hDEAD_BEEF));
        chk("s6_line_hi", 256'(rdat[2][255:224]), 256'(32'h0BAD_F00D));

        // Randomised traffic, including dropped requests and write+read pairs.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 25; n++) begin
                bit          wr, drop, keep;
                logic [31:0] a;
                wr   = 1'($urandom_range(0, 1));
                a    = $urandom;
                drop = ($urandom_range(0, 3) == 0);
                keep = wr && ($urandom_range(0, 3) == 0);
                run(i, wr, a, $urandom, drop, keep);
                if (keep) run(i, 1'b0, a, 32'h0, 1'b0, 1'b0);
                idle(i, int'($urandom_range(0, 2)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
